// File: rtl/pc_branch_sequencer_pkg.sv
// Shared types and widths for the PC sequencer and its target calculator.
package pc_branch_sequencer_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned BR_IMM_W = 16;
    localparam int unsigned J_IDX_W  = 26;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned RCNT_W   = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_branch_sequencer_branch_target_calc.sv
// Combinational branch and jump target generation, shared with the EX-stage adder.
module branch_target_calc
    import pc_branch_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]     br_pc4,
    input  logic [BR_IMM_W-1:0] br_imm,
    input  logic [PC_W-1:0]     j_pc4,
    input  logic [J_IDX_W-1:0]  j_idx,
    output logic [PC_W-1:0]     br_target_c,
    output logic [PC_W-1:0]     j_target_c
);

    localparam int unsigned SEXT_W = PC_W - BR_IMM_W - 2;
    localparam int unsigned J_HI_W = PC_W - J_IDX_W - 2;

    logic [PC_W-1:0] br_offset_c;
    logic            unused_j_pc4_c;

    // Word offset: sign-extended immediate scaled by 4; sum wraps modulo 2^32.
    assign br_offset_c = {{SEXT_W{br_imm[BR_IMM_W-1]}}, br_imm, 2'b00};
    assign br_target_c = br_pc4 + br_offset_c;

    // Jump stays inside the current 256 MB region of the jump's PC+4.
    assign j_target_c = {j_pc4[PC_W-1 -: J_HI_W], j_idx, 2'b00};

    // Low PC+4 bits do not participate in the jump target.
    assign unused_j_pc4_c = ^j_pc4[PC_W-J_HI_W-1:0];

endmodule

// File: rtl/pc_branch_sequencer.sv
// PC register, redirect arbitration, post-branch flush FSM and redirect counter.
module pc_branch_sequencer
    import pc_branch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Stall,
    input  logic                BranchEX,
    input  logic                BranchCond,
    input  logic [BR_IMM_W-1:0] BranchImm,
    input  logic [PC_W-1:0]     BranchPC4,
    input  logic                JumpID,
    input  logic [J_IDX_W-1:0]  JumpIdx,
    input  logic [PC_W-1:0]     JumpPC4,
    output logic [PC_W-1:0]     PC,
    output logic [PC_W-1:0]     PCPlus4,
    output logic                FlushIFID,
    output logic                FlushIDEX,
    output logic                Redirect,
    output logic [RCNT_W-1:0]   RedirectCount
);

    localparam logic [CNT_W-1:0]  FLUSH_CNT = CNT_W'(FLUSH_CYCLES);
    localparam logic              FLUSH_EN  = (FLUSH_CNT != '0);
    localparam logic [RCNT_W-1:0] RCNT_MAX  = '1;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    logic [PC_W-1:0]   br_target_c;
    logic [PC_W-1:0]   j_target_c;
    logic [PC_W-1:0]   pc_plus4_c;
    logic              take_br_c;
    logic              take_j_c;
    logic              in_flush_c;

    branch_target_calc u_target (
        .br_pc4      (BranchPC4),
        .br_imm      (BranchImm),
        .j_pc4       (JumpPC4),
        .j_idx       (JumpIdx),
        .br_target_c (br_target_c),
        .j_target_c  (j_target_c)
    );

    // Redirect causes; everything is masked while reset is asserted.
    assign take_br_c  = Rst & BranchEX & BranchCond;
    assign take_j_c   = Rst & JumpID & ~take_br_c & ~Stall & (state_q == ST_RUN);
    assign in_flush_c = Rst & (state_q == ST_FLUSH);
    assign pc_plus4_c = pc_q + PC_W'(4);

    // Next-state, next-PC and counter updates; flush controls are same-cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        rcnt_d    = rcnt_q;
        FlushIFID = take_br_c | take_j_c | in_flush_c;
        FlushIDEX = take_br_c;
        Redirect  = take_br_c | take_j_c;

        if (take_br_c) begin
            pc_d = br_target_c;
        end else if (take_j_c) begin
            pc_d = j_target_c;
        end else if (!Stall) begin
            pc_d = pc_plus4_c;
        end

        if (Redirect && (rcnt_q != RCNT_MAX)) begin
            rcnt_d = rcnt_q + RCNT_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (take_br_c && FLUSH_EN) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_CNT;
                end
            end
            ST_FLUSH: begin
                if (take_br_c && FLUSH_EN) begin
                    cnt_d = FLUSH_CNT;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, PC and counter registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign PC            = pc_q;
    assign PCPlus4       = pc_plus4_c;
    assign RedirectCount = rcnt_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Randomized and directed check of the PC sequencer against a behavioural model.
module tb_pc_branch_sequencer;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 1;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchEX = 1'b0;
    logic        BranchCond = 1'b0;
    logic [15:0] BranchImm = '0;
    logic [31:0] BranchPC4 = '0;
    logic        JumpID = 1'b0;
    logic [25:0] JumpIdx = '0;
    logic [31:0] JumpPC4 = '0;

    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FlushIFID;
    logic        FlushIDEX;
    logic        Redirect;
    logic [15:0] RedirectCount;

    pc_branch_sequencer #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Stall         (Stall),
        .BranchEX      (BranchEX),
        .BranchCond    (BranchCond),
        .BranchImm     (BranchImm),
        .BranchPC4     (BranchPC4),
        .JumpID        (JumpID),
        .JumpIdx       (JumpIdx),
        .JumpPC4       (JumpPC4),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .FlushIFID     (FlushIFID),
        .FlushIDEX     (FlushIDEX),
        .Redirect      (Redirect),
        .RedirectCount (RedirectCount)
    );

    always #5 Clk = ~Clk;

    int errs = 0;
    int checks = 0;

    // Reference state: fetch address, flush cycles still owed, redirects seen.
    logic [31:0] m_pc;
    int          m_flush_left;
    int          m_rcnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_br_target();
        int off;
        off = int'($signed(BranchImm)) * 4;
        return BranchPC4 + 32'(off);
    endfunction

    function automatic logic [31:0] exp_j_target();
        return (JumpPC4 & 32'hF000_0000) | (32'(JumpIdx) << 2);
    endfunction

    task automatic idle();
        Stall = 1'b0; BranchEX = 1'b0; BranchCond = 1'b0; JumpID = 1'b0;
        BranchImm = '0; BranchPC4 = '0; JumpIdx = '0; JumpPC4 = '0;
    endtask

    // One clock: check same-cycle flush controls, advance model, check registers.
    task automatic step(input bit chk);
        bit          tb_br;
        bit          tb_j;
        logic [31:0] nxt;
        @(negedge Clk);
        tb_br = BranchEX && BranchCond;
        tb_j  = JumpID && !tb_br && (m_flush_left == 0) && !Stall;
        if (chk) begin
            check_eq("flush_ifid", 32'(FlushIFID), 32'(tb_br || tb_j || (m_flush_left > 0)));
            check_eq("flush_idex", 32'(FlushIDEX), 32'(tb_br));
            check_eq("redirect", 32'(Redirect), 32'(tb_br || tb_j));
        end
        if (tb_br)      nxt = exp_br_target();
        else if (tb_j)  nxt = exp_j_target();
        else if (Stall) nxt = m_pc;
        else            nxt = m_pc + 32'd4;
        @(posedge Clk);
        m_pc = nxt;
        if (tb_br) m_flush_left = FLUSH_CYCLES;
        else if (m_flush_left > 0) m_flush_left--;
        if ((tb_br || tb_j) && m_rcnt < 65535) m_rcnt++;
        #1;
        if (chk) begin
            check_eq("pc", PC, m_pc);
            check_eq("pc_plus4", PCPlus4, m_pc + 32'd4);
            check_eq("redirect_count", 32'(RedirectCount), 32'(m_rcnt));
        end
    endtask

    initial begin
        m_pc = RESET_PC; m_flush_left = 0; m_rcnt = 0;

        // Reset with active inputs: outputs must be gated.
        idle(); BranchEX = 1'b1; BranchCond = 1'b1; JumpID = 1'b1;
        #2;
        check_eq("rst_pc", PC, RESET_PC);
        check_eq("rst_pc4", PCPlus4, RESET_PC + 32'd4);
        check_eq("rst_ifid", 32'(FlushIFID), 32'd0);
        check_eq("rst_idex", 32'(FlushIDEX), 32'd0);
        check_eq("rst_redir", 32'(Redirect), 32'd0);
        check_eq("rst_rcnt", 32'(RedirectCount), 32'd0);
        @(posedge Clk); #1;
        idle(); Rst = 1'b1;

        // Free run.
        for (int i = 0; i < 3; i++) step(1'b1);
        check_eq("free_run_pc", PC, 32'h0000_000C);

        // Backward branch to 0, then one flush cycle.
        BranchEX = 1'b1; BranchCond = 1'b1; BranchPC4 = 32'h10; BranchImm = 16'hFFFC;
        step(1'b1);
        check_eq("br_back_pc", PC, 32'h0);
        idle(); step(1'b1); step(1'b1);

        // Branch beats stall; untaken branch with stall holds.
        BranchEX = 1'b1; BranchCond = 1'b1; BranchPC4 = 32'h10; BranchImm = 16'h0003; Stall = 1'b1;
        step(1'b1);
        check_eq("br_stall_pc", PC, 32'h1C);
        BranchCond = 1'b0;
        step(1'b1);
        check_eq("stall_hold_pc", PC, 32'h1C);
        idle(); step(1'b1);

        // Jump from RUN.
        JumpID = 1'b1; JumpPC4 = 32'h24; JumpIdx = 26'h40;
        step(1'b1);
        check_eq("jump_pc", PC, 32'h100);

        // Stalled jump is suppressed.
        Stall = 1'b1; step(1'b1);
        check_eq("jump_stall_pc", PC, 32'h100);

        // Branch and jump together; then jump during flush is ignored.
        idle(); BranchEX = 1'b1; BranchCond = 1'b1; BranchPC4 = 32'h200; BranchImm = 16'h0;
        JumpID = 1'b1; JumpIdx = 26'hC0;
        step(1'b1);
        check_eq("br_over_j_pc", PC, 32'h200);
        BranchEX = 1'b0; BranchCond = 1'b0;
        step(1'b1);
        check_eq("j_in_flush_pc", PC, 32'h204);

        // Target wraps modulo 2^32.
        idle(); BranchEX = 1'b1; BranchCond = 1'b1; BranchPC4 = 32'hFFFF_FFFC; BranchImm = 16'h0001;
        step(1'b1);
        check_eq("wrap_pc", PC, 32'h0);

        // Asynchronous reset while in FLUSH.
        idle(); #1;
        check_eq("in_flush_ifid", 32'(FlushIFID), 32'd1);
        Rst = 1'b0; BranchEX = 1'b1; BranchCond = 1'b1; JumpID = 1'b1;
        #1;
        check_eq("mid_rst_pc", PC, RESET_PC);
        check_eq("mid_rst_ifid", 32'(FlushIFID), 32'd0);
        check_eq("mid_rst_idex", 32'(FlushIDEX), 32'd0);
        check_eq("mid_rst_rcnt", 32'(RedirectCount), 32'd0);
        m_pc = RESET_PC; m_flush_left = 0; m_rcnt = 0;
        @(posedge Clk); #1;
        check_eq("mid_rst_hold_pc", PC, RESET_PC);
        idle(); Rst = 1'b1;
        step(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            Stall      = ($urandom_range(0, 3) == 0);
            BranchEX   = ($urandom_range(0, 3) == 0);
            BranchCond = $urandom_range(0, 1) == 1;
            BranchImm  = 16'($urandom);
            BranchPC4  = $urandom & 32'hFFFF_FFFC;
            JumpID     = ($urandom_range(0, 3) == 0);
            JumpIdx    = 26'($urandom);
            JumpPC4    = $urandom & 32'hFFFF_FFFC;
            step(1'b1);
        end

        // Saturate the redirect counter.
        idle(); BranchEX = 1'b1; BranchCond = 1'b1; BranchPC4 = 32'h40; BranchImm = 16'h0;
        for (int i = 0; i < 65540; i++) step(1'b0);
        step(1'b1);
        check_eq("rcnt_sat", 32'(RedirectCount), 32'h0000_FFFF);
        idle(); step(1'b1); step(1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
